// File: rtl/fft_out_serializer_if.sv
// rtl/fft_out_serializer_if.sv - frame-in / word-out stream bundle for fft_out_serializer
//
// Signals:
//   input_valid, in, input_ready       : wide frame handshake (producer -> serializer)
//   output_valid, out, out_last,
//   output_ready                       : narrow word handshake (serializer -> consumer)
//   overflow                           : sticky dropped-frame flag from the serializer
// Modports:
//   master : environment side (drives frames, accepts words)
//   slave  : serializer side
interface fft_out_serializer_if #(
    parameter int INPUT_SIZE  = 256,
    parameter int OUTPUT_SIZE = 16
);
    logic                   input_valid;
    logic [INPUT_SIZE-1:0]  in;
    logic                   input_ready;
    logic                   output_valid;
    logic                   output_ready;
    logic [OUTPUT_SIZE-1:0] out;
    logic                   out_last;
    logic                   overflow;

    modport master (
        output input_valid, in, output_ready,
        input  input_ready, output_valid, out, out_last, overflow
    );

    modport slave (
        input  input_valid, in, output_ready,
        output input_ready, output_valid, out, out_last, overflow
    );
endinterface

// File: rtl/fft_out_serializer.sv
// rtl/fft_out_serializer.sv - splits wide FFT result frames into a stream of narrow words
//
// Ports:
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : fft_out_serializer_if.slave
//             in/input_valid/input_ready  - one frame accepted on input_valid && input_ready
//             out/output_valid/output_ready/out_last - words low slice first, out_last on word NUM_WORDS-1
//             overflow - sticky, set when a frame is offered while input_ready is low
//
// One active frame drains through a shift register while at most one further
// frame waits in the pending register. All handshake outputs are registers.
module fft_out_serializer #(
    parameter int INPUT_SIZE  = 256,
    parameter int OUTPUT_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    fft_out_serializer_if.slave     bus
);
    localparam int NUM_WORDS = INPUT_SIZE / OUTPUT_SIZE;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state;
    logic [INPUT_SIZE-1:0]  active;
    logic [INPUT_SIZE-1:0]  pending;
    logic                   pending_full;
    logic [IDX_W-1:0]       idx;
    logic [OUTPUT_SIZE-1:0] out_q;
    logic                   out_last_q;
    logic                   output_valid_q;
    logic                   overflow_q;

    logic accept;
    logic consume;
    logic consume_last;

    // input_ready depends only on a register, so there is no path from output_ready.
    assign bus.input_ready  = ~pending_full;
    assign bus.output_valid = output_valid_q;
    assign bus.out          = out_q;
    assign bus.out_last     = out_last_q;
    assign bus.overflow     = overflow_q;

    assign accept       = bus.input_valid & ~pending_full;
    assign consume      = output_valid_q & bus.output_ready;
    assign consume_last = consume & out_last_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            active         <= '0;
            pending        <= '0;
            pending_full   <= 1'b0;
            idx            <= '0;
            out_q          <= '0;
            out_last_q     <= 1'b0;
            output_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            if (bus.input_valid && pending_full) begin
                overflow_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        // Word 0 goes straight to the output register; the
                        // shift register keeps only the words still to come.
                        out_q          <= bus.in[OUTPUT_SIZE-1:0];
                        active         <= bus.in >> OUTPUT_SIZE;
                        idx            <= '0;
                        out_last_q     <= (NUM_WORDS == 1);
                        output_valid_q <= 1'b1;
                        state          <= SEND;
                    end
                end

                SEND: begin
                    if (consume_last) begin
                        // Frame boundary: reload without a bubble when possible.
                        if (pending_full) begin
                            out_q        <= pending[OUTPUT_SIZE-1:0];
                            active       <= pending >> OUTPUT_SIZE;
                            pending      <= '0;
                            pending_full <= 1'b0;
                            idx          <= '0;
                            out_last_q   <= (NUM_WORDS == 1);
                        end else if (accept) begin
                            out_q      <= bus.in[OUTPUT_SIZE-1:0];
                            active     <= bus.in >> OUTPUT_SIZE;
                            idx        <= '0;
                            out_last_q <= (NUM_WORDS == 1);
                        end else begin
                            active         <= '0;
                            out_q          <= '0;
                            out_last_q     <= 1'b0;
                            output_valid_q <= 1'b0;
                            state          <= IDLE;
                        end
                    end else begin
                        if (consume) begin
                            out_q      <= active[OUTPUT_SIZE-1:0];
                            active     <= active >> OUTPUT_SIZE;
                            idx        <= idx + 1'b1;
                            out_last_q <= ((idx + 1'b1) == LAST_IDX);
                        end
                        if (accept) begin
                            pending      <= bus.in;
                            pending_full <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_out_serializer.sv
// tb/tb_fft_out_serializer.sv - self-checking bench for fft_out_serializer
module tb_fft_out_serializer;
    localparam int IS = 256;
    localparam int OS = 16;
    localparam int NW = IS / OS;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    // Reference model: every word accepted but not yet consumed, in stream order.
    logic [OS-1:0] exp_q[$];
    bit            exp_ovf;
    bit            prev_stall;
    logic [OS-1:0] prev_out;
    logic          prev_last;

    fft_out_serializer_if #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS)) bus();

    fft_out_serializer #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frames still held by the DUT: a partly drained active frame plus maybe one pending.
    function automatic int frames_held();
        return (exp_q.size() + NW - 1) / NW;
    endfunction

    // One clock cycle: compare against the model, update the model for the edge, advance.
    task automatic step();
        bit exp_ready;
        bit exp_valid;
        bit acc;
        bit con;
        exp_ready = (frames_held() < 2);
        exp_valid = (exp_q.size() > 0);
        if (prev_stall) begin
            chk("hold_out", bus.out, prev_out);
            chk("hold_last", bus.out_last, prev_last);
            chk("hold_valid", bus.output_valid, 1);
        end
        chk("input_ready", bus.input_ready, exp_ready);
        chk("output_valid", bus.output_valid, exp_valid);
        chk("overflow", bus.overflow, exp_ovf);
        if (exp_valid) begin
            chk("out", bus.out, exp_q[0]);
            chk("out_last", bus.out_last, (exp_q.size() % NW) == 1);
        end else begin
            chk("idle_out", bus.out, 0);
            chk("idle_last", bus.out_last, 0);
        end
        acc = bus.input_valid && exp_ready;
        con = exp_valid && bus.output_ready;
        if (bus.input_valid && !exp_ready) exp_ovf = 1'b1;
        prev_stall = exp_valid && !bus.output_ready;
        prev_out   = bus.out;
        prev_last  = bus.out_last;
        if (con) void'(exp_q.pop_front());
        if (acc) begin
            for (int k = 0; k < NW; k++) exp_q.push_back(bus.in[k*OS +: OS]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        bus.input_valid = 1'b0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", (exp_q.size() == 0), 1);
    endtask

    function automatic logic [IS-1:0] pattern_frame(input logic [OS-1:0] base);
        logic [IS-1:0] f;
        for (int k = 0; k < NW; k++) f[k*OS +: OS] = base + OS'(k);
        return f;
    endfunction

    function automatic logic [IS-1:0] random_frame();
        logic [IS-1:0] f;
        for (int k = 0; k < IS / 32; k++) f[k*32 +: 32] = $urandom;
        return f;
    endfunction

    initial begin
        logic [1:0] bp;
        checks = 0;
        errors = 0;
        exp_ovf = 1'b0;
        prev_stall = 1'b0;
        prev_out = '0;
        prev_last = 1'b0;
        bus.input_valid = 1'b0;
        bus.in = '0;
        bus.output_ready = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        chk("rst_input_ready", bus.input_ready, 1);
        chk("rst_output_valid", bus.output_valid, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_overflow", bus.overflow, 0);
        step();

        // Single frame 0x0001..0x0010, ready held high
        bus.output_ready = 1'b1;
        bus.in = pattern_frame(16'h0001);
        bus.input_valid = 1'b1;
        step();
        bus.input_valid = 1'b0;
        chk("first_word", bus.out, 16'h0001);
        repeat (NW + 2) step();
        chk("single_done_valid", bus.output_valid, 0);

        // Backpressure with ready pattern 1,0,0,1
        bus.in = pattern_frame(16'h0100);
        bus.input_valid = 1'b1;
        bus.output_ready = 1'b1;
        step();
        bus.input_valid = 1'b0;
        for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
            bp = 2'(c % 4);
            bus.output_ready = (bp == 2'd0 || bp == 2'd3);
            step();
        end
        drain(100);

        // Back-to-back A, B, then C offered while B is pending
        bus.output_ready = 1'b1;
        bus.in = pattern_frame(16'h0A00);
        bus.input_valid = 1'b1;
        step();
        bus.in = pattern_frame(16'h0B00);
        step();
        chk("b2b_pending_blocks", bus.input_ready, 0);
        bus.in = pattern_frame(16'h0C00);
        repeat (3) step();
        bus.input_valid = 1'b0;
        chk("ovf_sticky", bus.overflow, 1);
        drain(100);
        chk("ovf_after_drain", bus.overflow, 1);

        // Async reset mid-frame after word 5 consumed
        bus.in = pattern_frame(16'h0500);
        bus.input_valid = 1'b1;
        step();
        bus.input_valid = 1'b0;
        repeat (5) step();
        chk("pre_reset_word", bus.out, 16'h0505);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid", bus.output_valid, 0);
        chk("async_out", bus.out, 0);
        chk("async_last", bus.out_last, 0);
        chk("async_overflow", bus.overflow, 0);
        chk("async_ready", bus.input_ready, 1);
        exp_q.delete();
        exp_ovf = 1'b0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        bus.in = pattern_frame(16'h0700);
        bus.input_valid = 1'b1;
        step();
        bus.input_valid = 1'b0;
        chk("post_reset_word0", bus.out, 16'h0700);
        drain(100);

        // Random loopback: 100 frames with random valid/ready gaps
        for (int f = 0; f < 100; f++) begin
            int tries;
            bit sent;
            sent = 1'b0;
            tries = 0;
            bus.in = random_frame();
            while (!sent && tries < 400) begin
                bus.input_valid = ($urandom_range(0, 3) != 0);
                bus.output_ready = ($urandom_range(0, 3) != 0);
                sent = bus.input_valid && (frames_held() < 2);
                step();
                tries++;
            end
            chk("loop_send_timeout", sent, 1);
        end
        bus.output_ready = 1'b1;
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_out_serializer.md
# fft_out_serializer

- Splits each wide result frame from the 8-point FFT core (256 bits = 8 complex samples of 32 bits) into 16 consecutive 16-bit words.
- Streams the words out over a valid/ready handshake in the same word order the input deserializer uses to pack frames, so a deserializer→FFT→serializer chain is order-preserving.
- Provides one frame of buffering (active + pending), so the FFT can hand over a new frame while the previous one is still draining.
- A sticky flag records frames dropped because no buffer was free.

## Interface
- INPUT_SIZE, 256, width of one input frame in bits.
- OUTPUT_SIZE, 16, width of one output word in bits; INPUT_SIZE must be an integer multiple of OUTPUT_SIZE.
- Derived (local):
  - NUM_WORDS = INPUT_SIZE/OUTPUT_SIZE (16 by default).
  - Word counter width = $clog2(NUM_WORDS).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- input_valid  in  1  `in` carries a frame this cycle.
- in  in  INPUT_SIZE  frame; word k is in[k*OUTPUT_SIZE +: OUTPUT_SIZE].
- input_ready  out  1  = !pending_full; a frame is accepted on a cycle with input_valid && input_ready.
- output_valid  out  1  `out` holds a valid word.
- output_ready  in  1  downstream accepts the word this cycle.
- out  out  OUTPUT_SIZE  current word (registered).
- out_last  out  1  high with the final word (k = NUM_WORDS-1) of a frame.
- overflow  out  1  sticky; set when input_valid arrives with input_ready low.

## Operation
Storage and state:
- Active shift register holds the frame being emitted.
- Pending register holds at most one further frame; pending_full flag.
- Word counter idx runs 0..NUM_WORDS-1.
- FSM: IDLE (active empty, output_valid=0) and SEND (output_valid=1).

Word emission:
- Words leave in order k = 0, 1, …, NUM_WORDS-1 (low slice first).
- A word is consumed on output_valid && output_ready. On consume, idx increments and the next word is presented.
- While output_ready is low, out, out_last and output_valid hold stable.

Frame acceptance (one frame accepted per cycle at most):
- IDLE + accept: frame loads into active; idx=0; go to SEND.
- SEND, not consuming the last word, + accept: frame loads into pending; pending_full=1.
- SEND, consuming the last word, pending_full=1: pending moves to active; idx=0; pending_full=0; stay in SEND with no bubble. No accept is possible this cycle, since input_ready=0.
- SEND, consuming the last word, pending empty, + accept: frame goes directly to active; stay in SEND with no bubble.
- SEND, consuming the last word, pending empty, no accept: go to IDLE; output_valid=0; out=0; out_last=0.

Overflow:
- input_valid && !input_ready: the frame is discarded and overflow is set.
- overflow clears only on reset.

Other rules:
- Arithmetic: pure data movement; no width change within a word; idx wraps NUM_WORDS-1 → 0 only on a frame load.
- Reset (async, any time including mid-frame):
  - IDLE; idx=0; pending_full=0; active/pending data cleared.
  - output_valid=0, out=0, out_last=0, overflow=0, input_ready=1.
  - The in-flight frame is lost. Inputs are ignored while reset_n=0.

## Timing
- Latency: a frame accepted at edge N gives word 0 on out with output_valid=1 after edge N (visible in cycle N+1).
- Throughput: with output_ready held high, one word per cycle. NUM_WORDS cycles per frame; consecutive frames have no idle cycle.
- input_ready is driven from registered state only, with no combinational path from output_ready.
- Handshake outputs (output_valid, out, out_last) are registers; none combinationally depends on output_ready.
- out_last asserts in the same cycle as the last word and deasserts after that word is consumed.

## Test plan
- Single frame, output_ready=1, words 0x0001..0x0010 accepted at edge N:
  - out = 0x0001..0x0010 on cycles N+1..N+16.
  - out_last only on cycle N+16; output_valid=0 from cycle N+17.
- Backpressure, output_ready toggled 1,0,0,1 repeatedly: every word held stable while ready=0; all 16 words delivered in order, none duplicated or skipped.
- Back-to-back, frame A (0x0A00+k) then frame B (0x0B00+k) on consecutive cycles, ready=1:
  - B goes to pending; input_ready=0 until A's last word is consumed.
  - 32 consecutive valid words, A then B; out_last on words 16 and 32.
- Overflow: while A is sending and B is pending, present C: input_ready=0, overflow=1 stays high, C never appears on out.
- Reset mid-frame, reset_n low after word 5: outputs go 0 immediately (async); after release, a new frame starts at word 0 and overflow=0.
- Loopback: input deserializer → this block with random input_valid/output_ready gaps, 100 frames: output word stream equals input word stream.
